btb_predictor: RTL
==================

// Module: btb_predictor
// PURPOSE
//  Parametrised branch target buffer with per-entry N-bit saturating direction counters.
//  Generalises the fixed 2-bit, direct-mapped predictor in configurable depth, tag width,
//  counter width and associativity (1 or 2 ways, LRU).
//  IF stage: combinational lookup on the fetch PC. EX stage: one resolved-branch update per cycle.
//  Built-in update and mispredict performance counters.
// PARAMETERS
//  XLEN     32  PC/target width
//  ENTRIES  64  total entries, power of 2
//  WAYS     1   associativity, 1 or 2; SETS=ENTRIES/WAYS, IDX_W=$clog2(SETS)
//  TAG_W    8   stored tag bits; elaboration error if XLEN < IDX_W+TAG_W+2
//  CTR_W    2   direction counter width, >=1
// PORTS
//  clk_i           in   1     clock
//  rst_i           in   1     synchronous reset, active-high
//  flush_i         in   1     invalidate all entries (sync)
//  pred_pc_i       in   XLEN  fetch PC
//  pred_hit_o      out  1     tag match on valid entry
//  pred_taken_o    out  1     hit & (is_jump | ctr[CTR_W-1])
//  pred_target_o   out  XLEN  stored target on hit, else 0
//  upd_valid_i     in   1     resolved control-flow instruction this cycle
//  upd_pc_i        in   XLEN  PC of resolved instruction
//  upd_is_jump_i   in   1     1=JAL/JALR (unconditional), 0=conditional branch
//  upd_taken_i     in   1     actual direction (forced 1 when upd_is_jump_i)
//  upd_target_i    in   XLEN  actual target
//  stat_upd_o      out  32    count of accepted updates
//  stat_mispred_o  out  32    count of mispredicted updates
// BEHAVIOUR
//  - Address split: idx=pc[IDX_W+1:2], tag=pc[IDX_W+TAG_W+1:IDX_W+2]; pc[1:0] ignored.
//  - Lookup is combinational, zero latency. It reads pre-edge state.
//  - No write->read bypass: an update becomes visible to lookups the cycle after its edge.
//  - Update (upd_valid_i=1), second lookup at upd_pc_i on pre-edge state:
//    * hit, conditional: counter +1 if taken, -1 if not, saturating at 0 and 2^CTR_W-1.
//      Target rewritten when taken.
//    * hit, jump: counter set to max, is_jump=1, target rewritten.
//    * miss & taken: allocate. Victim is the invalid way (way0 first), else the LRU way.
//      Fields: tag, target, is_jump, valid=1.
//      ctr = 2^(CTR_W-1) (weakly taken), or max for a jump.
//    * miss & not taken: no allocation, no state change except stats.
//  - LRU: 1 bit per set, WAYS=2 only. Set to the way not touched on an update hit or allocation.
//    Lookups never change LRU.
//  - Mispredict on an update, counted into stat_mispred_o:
//    * (prior pred_taken != upd_taken_i), or
//    * (both taken & stored target != upd_target_i).
//    * A miss with taken counts as a mispredict.
//  - stat_upd_o increments on every upd_valid_i. Both stats wrap modulo 2^32.
//  - Priority: rst_i > flush_i > update.
//    * rst_i clears valid, LRU, counters, targets and both stats.
//    * flush_i clears valid and LRU only. An update in the same cycle as flush_i is dropped.
//      Stats still count it.
//  - Reset values: pred_hit_o=0, pred_taken_o=0, pred_target_o=0, stats=0.
//    Any lookup in the cycle after reset misses.
//  - Aliasing: different PCs with the same idx and tag share an entry. Accepted, not detected.
// STRUCTURE
//  - btb_pkg:
//    * btb_entry_t struct {valid, is_jump, tag, ctr, target}, parametrised via localparams.
//    * Function ctr_next(ctr, taken).
//    * Constants CTR_MAX and CTR_WEAK_T.
//  - Sub-module sat_counter #(CTR_W): combinational saturating inc/dec, instantiated in the update path.
//  - Entry storage: flop array [SETS][WAYS] (no SRAM macro). Reset loop in always_ff.
// TESTING
//  1. rst_i 1 cycle, lookup pc=0x100 -> pred_hit_o=0, pred_target_o=0, stats=0.
//  2. Update pc=0x100 taken target=0x200 (conditional, CTR_W=2) -> next cycle lookup 0x100:
//     hit=1, taken=1, target=0x200, ctr=2, stat_mispred_o=1.
//  3. Two not-taken updates at 0x100 -> ctr 2->1->0, pred_taken_o=0 after the first.
//     Third not-taken holds ctr=0 (saturation). Then 4 taken -> ctr stops at 3.
//  4. WAYS=2, SETS=32: allocate 0x100 and 0x100+(32<<2), update the first (hit), then allocate
//     a third alias -> the second entry is evicted, the first remains.
//  5. Update jump pc=0x80 target=0x400 in the same cycle as flush_i -> next cycle lookup 0x80 misses.
//     stat_upd_o incremented. A repeat jump update then hits with taken=1.
//  6. Update and lookup same PC same cycle -> lookup reflects old state. Next cycle reflects new state.

Source files
------------

// File: rtl/btb_pkg.sv
// Shared types and helpers for the branch target buffer.
// The struct and constants describe the default geometry; the top builds its own entry type from its parameters.
package btb_pkg;
  localparam int XLEN_DEF  = 32;
  localparam int TAG_W_DEF = 8;
  localparam int CTR_W_DEF = 2;

  localparam logic [CTR_W_DEF-1:0] CTR_MAX    = '1;
  localparam logic [CTR_W_DEF-1:0] CTR_WEAK_T = CTR_W_DEF'(1 << (CTR_W_DEF-1));

  typedef struct packed {
    logic                 valid;
    logic                 is_jump;
    logic [TAG_W_DEF-1:0] tag;
    logic [CTR_W_DEF-1:0] ctr;
    logic [XLEN_DEF-1:0]  target;
  } btb_entry_t;

  // Width-agnostic saturating step; callers pass their own maximum.
  function automatic logic [31:0] ctr_next(input logic [31:0] ctr, input logic taken,
                                           input logic [31:0] max);
    if (taken) return (ctr == max) ? ctr : ctr + 32'd1;
    else       return (ctr == '0)  ? ctr : ctr - 32'd1;
  endfunction
endpackage

// File: rtl/sat_counter.sv
// Combinational saturating up/down counter step.
module sat_counter
  import btb_pkg::*;
#(
  parameter int CTR_W = 2
) (
  input  logic [CTR_W-1:0] ctr_i,
  input  logic             inc_i,
  output logic [CTR_W-1:0] ctr_o
);
  localparam logic [31:0] MAX = 32'((64'(1) << CTR_W) - 64'(1));

  assign ctr_o = CTR_W'(ctr_next(32'(ctr_i), inc_i, MAX));
endmodule

// File: rtl/btb_predictor.sv
// Branch target buffer: 1- or 2-way, per-entry saturating direction counter,
// combinational fetch lookup, one resolved-branch update per cycle, perf counters.
module btb_predictor
  import btb_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 64,
  parameter int WAYS    = 1,
  parameter int TAG_W   = 8,
  parameter int CTR_W   = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] pred_pc_i,
  output logic            pred_hit_o,
  output logic            pred_taken_o,
  output logic [XLEN-1:0] pred_target_o,
  input  logic            upd_valid_i,
  input  logic [XLEN-1:0] upd_pc_i,
  input  logic            upd_is_jump_i,
  input  logic            upd_taken_i,
  input  logic [XLEN-1:0] upd_target_i,
  output logic [31:0]     stat_upd_o,
  output logic [31:0]     stat_mispred_o
);
  localparam int SETS  = ENTRIES / WAYS;
  localparam int IDX_W = $clog2(SETS);
  localparam logic [CTR_W-1:0] C_MAX  = '1;
  localparam logic [CTR_W-1:0] C_WEAK = CTR_W'(1 << (CTR_W-1));

  if (WAYS != 1 && WAYS != 2) begin : g_bad_ways
    $error("btb_predictor: WAYS must be 1 or 2");
  end
  if (XLEN < IDX_W + TAG_W + 2) begin : g_bad_xlen
    $error("btb_predictor: XLEN too small for IDX_W+TAG_W+2");
  end

  typedef struct packed {
    logic             valid;
    logic             is_jump;
    logic [TAG_W-1:0] tag;
    logic [CTR_W-1:0] ctr;
    logic [XLEN-1:0]  target;
  } entry_t;

  entry_t          ent_q [SETS][WAYS];
  entry_t          ent_d [SETS][WAYS];
  logic [SETS-1:0] lru_q, lru_d;
  logic [31:0]     stat_upd_q, stat_upd_d, stat_mis_q, stat_mis_d;

  logic [IDX_W-1:0] p_idx, u_idx;
  logic [TAG_W-1:0] p_tag, u_tag;
  logic             unused_pc;

  assign p_idx     = pred_pc_i[IDX_W+1:2];
  assign p_tag     = pred_pc_i[IDX_W+TAG_W+1:IDX_W+2];
  assign u_idx     = upd_pc_i[IDX_W+1:2];
  assign u_tag     = upd_pc_i[IDX_W+TAG_W+1:IDX_W+2];
  assign unused_pc = ^{pred_pc_i, upd_pc_i};

  // Fetch lookup; lowest matching way wins so aliased duplicates stay deterministic.
  logic   p_hit;
  entry_t p_ent;
  always_comb begin
    p_hit = 1'b0;
    p_ent = '0;
    for (int w = WAYS-1; w >= 0; w--) begin
      if (ent_q[p_idx][w].valid && ent_q[p_idx][w].tag == p_tag) begin
        p_hit = 1'b1;
        p_ent = ent_q[p_idx][w];
      end
    end
  end

  assign pred_hit_o    = p_hit;
  assign pred_taken_o  = p_hit & (p_ent.is_jump | p_ent.ctr[CTR_W-1]);
  assign pred_target_o = p_hit ? p_ent.target : '0;

  // Second lookup port for the update PC, on pre-edge state.
  logic       u_hit, u_way, u_vic, u_ptaken, u_taken, u_mis;
  entry_t     u_ent;
  logic [CTR_W-1:0] ctr_upd;
  always_comb begin
    u_hit = 1'b0;
    u_way = 1'b0;
    u_ent = '0;
    for (int w = WAYS-1; w >= 0; w--) begin
      if (ent_q[u_idx][w].valid && ent_q[u_idx][w].tag == u_tag) begin
        u_hit = 1'b1;
        u_way = 1'(w);
        u_ent = ent_q[u_idx][w];
      end
    end
    if (!ent_q[u_idx][0].valid)                    u_vic = 1'b0;
    else if (WAYS == 2 && !ent_q[u_idx][WAYS-1].valid) u_vic = 1'b1;
    else if (WAYS == 2)                            u_vic = lru_q[u_idx];
    else                                           u_vic = 1'b0;
  end

  assign u_taken  = upd_is_jump_i | upd_taken_i;
  assign u_ptaken = u_hit & (u_ent.is_jump | u_ent.ctr[CTR_W-1]);
  assign u_mis    = (u_ptaken != u_taken) |
                    (u_ptaken & u_taken & (u_ent.target != upd_target_i));

  sat_counter #(.CTR_W(CTR_W)) u_sat (
    .ctr_i (u_ent.ctr),
    .inc_i (u_taken),
    .ctr_o (ctr_upd)
  );

  always_comb begin
    ent_d      = ent_q;
    lru_d      = lru_q;
    stat_upd_d = stat_upd_q;
    stat_mis_d = stat_mis_q;
    if (upd_valid_i) begin
      stat_upd_d = stat_upd_q + 32'd1;
      if (u_mis) stat_mis_d = stat_mis_q + 32'd1;
    end
    if (flush_i) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++) ent_d[s][w].valid = 1'b0;
      lru_d = '0;
    end else if (upd_valid_i) begin
      if (u_hit) begin
        for (int w = 0; w < WAYS; w++) begin
          if (1'(w) == u_way) begin
            if (upd_is_jump_i) begin
              ent_d[u_idx][w].ctr     = C_MAX;
              ent_d[u_idx][w].is_jump = 1'b1;
              ent_d[u_idx][w].target  = upd_target_i;
            end else begin
              ent_d[u_idx][w].ctr = ctr_upd;
              if (upd_taken_i) ent_d[u_idx][w].target = upd_target_i;
            end
          end
        end
        if (WAYS == 2) lru_d[u_idx] = ~u_way;
      end else if (u_taken) begin
        for (int w = 0; w < WAYS; w++) begin
          if (1'(w) == u_vic) begin
            ent_d[u_idx][w].valid   = 1'b1;
            ent_d[u_idx][w].is_jump = upd_is_jump_i;
            ent_d[u_idx][w].tag     = u_tag;
            ent_d[u_idx][w].ctr     = upd_is_jump_i ? C_MAX : C_WEAK;
            ent_d[u_idx][w].target  = upd_target_i;
          end
        end
        if (WAYS == 2) lru_d[u_idx] = ~u_vic;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++) ent_q[s][w] <= '0;
      lru_q      <= '0;
      stat_upd_q <= '0;
      stat_mis_q <= '0;
    end else begin
      ent_q      <= ent_d;
      lru_q      <= lru_d;
      stat_upd_q <= stat_upd_d;
      stat_mis_q <= stat_mis_d;
    end
  end

  assign stat_upd_o     = stat_upd_q;
  assign stat_mispred_o = stat_mis_q;
endmodule
